// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, flag positions, FSM states.
// Helper predicates classify opcodes for the slice datapath and flag logic.
package alu_pkg;

    localparam logic [2:0] ADD_OP = 3'd0;
    localparam logic [2:0] ADC_OP = 3'd1;
    localparam logic [2:0] SUB_OP = 3'd2;
    localparam logic [2:0] SBC_OP = 3'd3;
    localparam logic [2:0] AND_OP = 3'd4;
    localparam logic [2:0] XOR_OP = 3'd5;
    localparam logic [2:0] OR_OP  = 3'd6;
    localparam logic [2:0] CP_OP  = 3'd7;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_sub(input logic [2:0] op);
        return (op == SUB_OP) || (op == SBC_OP) || (op == CP_OP);
    endfunction

    function automatic logic uses_cin(input logic [2:0] op);
        return (op == ADC_OP) || (op == SBC_OP);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; carry/borrow in and out, half-carry tap.
// Zero latency; one instance is time-shared across all slices of an operation.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [SLICE-1:0] y,
    output logic             cout,
    output logic             hc
);

    logic [SLICE:0] s;

    always_comb begin
        s = '0;
        case (op)
            ADD_OP, ADC_OP:         s = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
            SUB_OP, SBC_OP, CP_OP:  s = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, cin};
            AND_OP:                 s = {1'b0, a & b};
            XOR_OP:                 s = {1'b0, a ^ b};
            OR_OP:                  s = {1'b0, a | b};
            default:                s = '0;
        endcase
    end

    assign y    = s[SLICE-1:0];
    assign cout = s[SLICE];
    // With SLICE of 1, 2 or 4, bit 3 always ends a slice, so its carry is that slice's carry out.
    assign hc   = s[SLICE];

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: processes SLICE bits per cycle, done pulses WIDTH/SLICE edges after start.
// start is only sampled while idle; requests arriving while busy are dropped.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [2:0]       alu_op,
    input  logic             in_C,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       out_flags
);

    localparam int NS    = WIDTH / SLICE;
    localparam int IW    = (NS > 1) ? $clog2(NS) : 1;
    localparam int H_IDX = 4 / SLICE - 1;
    localparam logic [IW-1:0] LAST = IW'(NS - 1);
    localparam logic [IW-1:0] H_SL = IW'(H_IDX);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg, b_reg, res, res_next;
    logic [2:0]       op_reg;
    logic             carry, zero_acc, h_reg;
    logic [SLICE-1:0] sa, sb, sy;
    logic             scout, shc, h_now, z_now;
    logic [3:0]       flags_next;

    assign sa = a_reg[idx*SLICE +: SLICE];
    assign sb = b_reg[idx*SLICE +: SLICE];

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a    (sa),
        .b    (sb),
        .op   (op_reg),
        .cin  (carry),
        .y    (sy),
        .cout (scout),
        .hc   (shc)
    );

    always_comb begin
        res_next = res;
        res_next[idx*SLICE +: SLICE] = sy;
        h_now = (idx == H_SL) ? shc : h_reg;
        z_now = zero_acc & (sy == '0);
        flags_next = '0;
        flags_next[FLAG_Z] = z_now;
        flags_next[FLAG_N] = is_sub(op_reg);
        case (op_reg)
            AND_OP: begin
                flags_next[FLAG_H] = 1'b1;
                flags_next[FLAG_C] = 1'b0;
            end
            XOR_OP, OR_OP: begin
                flags_next[FLAG_H] = 1'b0;
                flags_next[FLAG_C] = 1'b0;
            end
            default: begin
                flags_next[FLAG_H] = h_now;
                flags_next[FLAG_C] = scout;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res       <= '0;
            op_reg    <= '0;
            carry     <= 1'b0;
            zero_acc  <= 1'b0;
            h_reg     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
            out_flags <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= in_A;
                        b_reg    <= in_B;
                        op_reg   <= alu_op;
                        carry    <= uses_cin(alu_op) ? in_C : 1'b0;
                        idx      <= '0;
                        zero_acc <= 1'b1;
                        h_reg    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res      <= res_next;
                    carry    <= scout;
                    zero_acc <= z_now;
                    h_reg    <= h_now;
                    if (idx == LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out       <= (op_reg == CP_OP) ? a_reg : res_next;
                        out_flags <= flags_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: 8-bit and 16-bit instances, directed and random operations
// scored against a full-width arithmetic reference model.
module tb_alu_serial;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  start_v;
    logic [15:0] a_v [2];
    logic [15:0] b_v [2];
    logic [2:0]  op_v [2];
    logic [1:0]  c_v;
    logic        busy8, done8, busy16, done16;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic [3:0]  fl8, fl16;

    always #5 clock = ~clock;

    alu_serial #(.WIDTH(8), .SLICE(4)) u8 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]),
        .in_A(a_v[0][7:0]), .in_B(b_v[0][7:0]), .alu_op(op_v[0]), .in_C(c_v[0]),
        .busy(busy8), .done(done8), .out(out8), .out_flags(fl8)
    );

    alu_serial #(.WIDTH(16), .SLICE(4)) u16 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]),
        .in_A(a_v[1]), .in_B(b_v[1]), .alu_op(op_v[1]), .in_C(c_v[1]),
        .busy(busy16), .done(done16), .out(out16), .out_flags(fl16)
    );

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-operand arithmetic, flags from their textual definitions.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, b,
                                          input logic c, input int w);
        longint mask = (64'd1 << w) - 1;
        longint ai = longint'(a) & mask;
        longint bi = longint'(b) & mask;
        longint ci = (op == 3'd1 || op == 3'd3) ? longint'(c) : 0;
        longint r;
        logic z, n, h, cf;
        logic [15:0] o;
        h = 1'b0; cf = 1'b0;
        n = (op == 3'd2 || op == 3'd3 || op == 3'd7);
        case (op)
            3'd0, 3'd1: begin
                r  = ai + bi + ci;
                cf = (r > mask);
                h  = ((ai % 16) + (bi % 16) + ci) > 15;
            end
            3'd4: begin r = ai & bi; h = 1'b1; end
            3'd5: r = ai ^ bi;
            3'd6: r = ai | bi;
            default: begin
                r  = ai - bi - ci;
                cf = (ai < bi + ci);
                h  = (ai % 16) < ((bi % 16) + ci);
            end
        endcase
        r = r & mask;
        z = (r == 0);
        o = (op == 3'd7) ? 16'(ai) : 16'(r);
        return {z, n, h, cf, o};
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy8 : busy16;
    endfunction

    task automatic issue(input int d, input logic [2:0] op, input logic [15:0] a, b,
                         input logic c, input bit hold, input logic [19:0] e,
                         input string tag, output int acc);
        int   n = 0;
        exp_t x;
        acc = -1;
        @(negedge clock);
        while (busy_of(d)) begin
            n++;
            if (n > 64) begin
                checks++; errors++;
                $display("FAIL %s idle_timeout: busy stuck high, required low within 64 cycles", tag);
                return;
            end
            @(negedge clock);
        end
        start_v[d] = 1'b1;
        a_v[d] = a; b_v[d] = b; op_v[d] = op; c_v[d] = c;
        @(posedge clock);
        #1;
        acc = cyc;
        chk({tag, " busy_after_start"}, 32'(busy_of(d)), 1);
        x.r = e[15:0]; x.f = e[19:16]; x.cyc = acc + ((d == 0) ? 2 : 4); x.tag = tag;
        if (d == 0) q0.push_back(x); else q1.push_back(x);
        if (!hold) start_v[d] = 1'b0;
    endtask

    task automatic rnd(input int d, input string tag);
        logic [2:0]  op = 3'($urandom_range(0, 7));
        logic [15:0] a = 16'($urandom);
        logic [15:0] b = 16'($urandom);
        logic        c = 1'($urandom);
        int          acc;
        if (d == 0) begin a[15:8] = '0; b[15:8] = '0; end
        issue(d, op, a, b, c, 1'b0, model(op, a, b, c, (d == 0) ? 8 : 16), tag, acc);
    endtask

    task automatic mon(input int d, input logic [15:0] o, input logic [3:0] f);
        exp_t x;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_done dut%0d: out=%0h flags=%b at cycle %0d, no operation outstanding",
                     d, o, f, cyc);
        end else begin
            if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
            chk({x.tag, " out"}, 32'(o), 32'(x.r));
            chk({x.tag, " flags"}, 32'(f), 32'(x.f));
            chk({x.tag, " done_cycle"}, cyc, x.cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (done8)  mon(0, {8'h00, out8}, fl8);
            if (done16) mon(1, out16, fl16);
        end
    end

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, acc;
        reset_n = 1'b0;
        start_v = '0;
        c_v = '0;
        for (int i = 0; i < 2; i++) begin a_v[i] = '0; b_v[i] = '0; op_v[i] = '0; end
        repeat (3) @(posedge clock);
        #1;
        chk("rst busy8", 32'(busy8), 0);
        chk("rst done8", 32'(done8), 0);
        chk("rst out8", 32'(out8), 0);
        chk("rst flags8", 32'(fl8), 0);
        chk("rst busy16", 32'(busy16), 0);
        chk("rst out16", 32'(out16), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // 8-bit directed table: {Z,N,H,C, result}
        issue(0, ADD_OP, 16'h3A, 16'hC6, 1'b0, 1'b0, {4'b1011, 16'h00}, "add_3a_c6", acc);
        issue(0, SBC_OP, 16'h3B, 16'h2A, 1'b1, 1'b0, {4'b0100, 16'h10}, "sbc_3b_2a", acc);
        issue(0, CP_OP,  16'h3C, 16'h2F, 1'b0, 1'b0, {4'b0110, 16'h3C}, "cp_3c_2f", acc);
        issue(0, AND_OP, 16'h5A, 16'h3F, 1'b0, 1'b0, {4'b0010, 16'h1A}, "and_5a_3f", acc);
        issue(0, ADC_OP, 16'hFF, 16'h00, 1'b1, 1'b0, {4'b1011, 16'h00}, "adc_ff_00", acc);
        issue(0, SUB_OP, 16'h00, 16'h01, 1'b0, 1'b0, {4'b0111, 16'hFF}, "sub_00_01", acc);
        issue(0, SUB_OP, 16'h05, 16'h03, 1'b1, 1'b0, {4'b0100, 16'h02}, "sub_ignores_c", acc);
        issue(0, ADD_OP, 16'h01, 16'h01, 1'b1, 1'b0, {4'b0000, 16'h02}, "add_ignores_c", acc);
        issue(0, XOR_OP, 16'h0F, 16'h0F, 1'b0, 1'b0, {4'b1000, 16'h00}, "xor_zero", acc);
        issue(0, OR_OP,  16'hA0, 16'h05, 1'b0, 1'b0, {4'b0000, 16'hA5}, "or_a0_05", acc);
        drain();

        // 16-bit: busy window and output stability during the run
        issue(1, ADD_OP, 16'h1234, 16'h0001, 1'b0, 1'b0, {4'b0000, 16'h1235}, "add16_1234", acc);
        drain();
        issue(1, ADD_OP, 16'h0FFF, 16'h0001, 1'b0, 1'b0, {4'b0010, 16'h1000}, "add16_0fff", acc);
        for (int i = 1; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk("add16 busy_mid", 32'(busy16), 1);
            chk("add16 out_hold", 32'(out16), 32'h1235);
        end
        @(posedge clock);
        #1;
        chk("add16 busy_end", 32'(busy16), 0);
        drain();

        // start held high: one result every 3 cycles
        issue(0, ADD_OP, 16'h10, 16'h20, 1'b0, 1'b1, {4'b0000, 16'h30}, "b2b_0", a0);
        issue(0, SUB_OP, 16'h10, 16'h20, 1'b0, 1'b1, {4'b0101, 16'hF0}, "b2b_1", a1);
        issue(0, OR_OP,  16'h10, 16'h20, 1'b0, 1'b0, {4'b0000, 16'h30}, "b2b_2", a2);
        chk("b2b period_1", a1 - a0, 3);
        chk("b2b period_2", a2 - a1, 3);
        drain();

        // start pulse during RUN must be ignored
        issue(0, AND_OP, 16'hF0, 16'h3C, 1'b0, 1'b0, {4'b0010, 16'h30}, "midrun_first", acc);
        @(negedge clock);
        start_v[0] = 1'b1; a_v[0] = 16'hFF; b_v[0] = 16'hFF; op_v[0] = ADD_OP;
        @(posedge clock);
        #1;
        start_v[0] = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            rnd(0, "rnd8");
        end
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            rnd(1, "rnd16");
        end
        drain();

        issue(0, OR_OP, 16'h81, 16'h00, 1'b0, 1'b0, {4'b0000, 16'h81}, "pre_reset", acc);
        drain();

        // reset pulse one edge into an operation: everything clears, no done follows
        @(negedge clock);
        start_v[0] = 1'b1; a_v[0] = 16'h11; b_v[0] = 16'h22; op_v[0] = ADD_OP; c_v[0] = 1'b0;
        @(posedge clock);
        #1;
        start_v[0] = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort busy8", 32'(busy8), 0);
        chk("abort done8", 32'(done8), 0);
        chk("abort out8", 32'(out8), 0);
        chk("abort flags8", 32'(fl8), 0);
        #2;
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("abort out8_after", 32'(out8), 0);

        // first edge after reset release accepts start
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        issue(0, SBC_OP, 16'h3B, 16'h2A, 1'b1, 1'b0, {4'b0100, 16'h10}, "post_reset", acc);
        drain();

        chk("q8 empty", q0.size(), 0);
        chk("q16 empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
